// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: allocates tags at the tail, collects CDB results, retires the
// head in program order and raises a registered flush when a retiring branch was mispredicted.
module reorder_buffer #(
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 ready_i,
  input  logic                 issue_valid_i,
  input  logic [1:0]           issue_kind_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 issue_pred_i,
  output logic [ROB_WIDTH-1:0] alloc_pos_o,
  output logic                 full_o,
  input  logic                 cdb_valid_i,
  input  logic [ROB_WIDTH-1:0] cdb_pos_i,
  input  logic [31:0]          cdb_val_i,
  input  logic                 cdb_taken_i,
  input  logic [31:0]          cdb_target_i,
  input  logic [ROB_WIDTH-1:0] qry1_pos_i,
  input  logic [ROB_WIDTH-1:0] qry2_pos_i,
  output logic                 qry1_done_o,
  output logic                 qry2_done_o,
  output logic [31:0]          qry1_val_o,
  output logic [31:0]          qry2_val_o,
  output logic                 commit_o,
  output logic [4:0]           commit_rd_o,
  output logic [ROB_WIDTH-1:0] commit_pos_o,
  output logic [31:0]          commit_val_o,
  output logic                 store_commit_o,
  output logic                 clear_o,
  output logic [31:0]          clear_pc_o
);

  localparam int unsigned Depth = 1 << ROB_WIDTH;
  localparam int unsigned CntW  = ROB_WIDTH + 1;
  localparam logic [1:0] KindBranch = 2'd1;
  localparam logic [1:0] KindStore  = 2'd2;

  logic [ROB_WIDTH-1:0] head_q, tail_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [Depth-1:0]     done_q;
  logic [1:0]           kind_q   [Depth];
  logic [4:0]           rd_q     [Depth];
  logic                 pred_q   [Depth];
  logic                 taken_q  [Depth];
  logic [31:0]          val_q    [Depth];
  logic [31:0]          target_q [Depth];

  logic                 commit_q, store_commit_q, clear_q;
  logic [4:0]           commit_rd_q;
  logic [ROB_WIDTH-1:0] commit_pos_q;
  logic [31:0]          commit_val_q, clear_pc_q;

  logic                 do_issue, do_cdb, do_commit, head_is_store, mispredict;
  logic [ROB_WIDTH-1:0] cdb_off;

  always_comb begin
    full_o        = (count_q == CntW'(Depth));
    alloc_pos_o   = tail_q;
    do_commit     = ready_i && (count_q != '0) && done_q[head_q];
    head_is_store = (kind_q[head_q] == KindStore);
    mispredict    = do_commit && (kind_q[head_q] == KindBranch) &&
                    (taken_q[head_q] != pred_q[head_q]);
    do_issue      = ready_i && issue_valid_i && !full_o && !clear_q;
    // A tag is live iff its distance from head is below the occupancy count.
    cdb_off       = cdb_pos_i - head_q;
    do_cdb        = ready_i && cdb_valid_i && !clear_q && ({1'b0, cdb_off} < count_q);
    count_d       = count_q + CntW'(do_issue) - CntW'(do_commit);

    qry1_done_o = done_q[qry1_pos_i] || (cdb_valid_i && (cdb_pos_i == qry1_pos_i));
    qry2_done_o = done_q[qry2_pos_i] || (cdb_valid_i && (cdb_pos_i == qry2_pos_i));
    qry1_val_o  = (cdb_valid_i && (cdb_pos_i == qry1_pos_i)) ? cdb_val_i : val_q[qry1_pos_i];
    qry2_val_o  = (cdb_valid_i && (cdb_pos_i == qry2_pos_i)) ? cdb_val_i : val_q[qry2_pos_i];

    commit_o       = commit_q;
    commit_rd_o    = commit_rd_q;
    commit_pos_o   = commit_pos_q;
    commit_val_o   = commit_val_q;
    store_commit_o = store_commit_q;
    clear_o        = clear_q;
    clear_pc_o     = clear_pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      done_q         <= '0;
      commit_q       <= 1'b0;
      store_commit_q <= 1'b0;
      clear_q        <= 1'b0;
      commit_rd_q    <= '0;
      commit_pos_q   <= '0;
      commit_val_q   <= '0;
      clear_pc_q     <= '0;
    end else if (!ready_i) begin
      commit_q       <= 1'b0;
      store_commit_q <= 1'b0;
      clear_q        <= 1'b0;
    end else begin
      commit_q       <= do_commit;
      store_commit_q <= do_commit && head_is_store;
      clear_q        <= mispredict;
      if (do_commit) begin
        commit_rd_q  <= head_is_store ? 5'd0 : rd_q[head_q];
        commit_pos_q <= head_q;
        commit_val_q <= val_q[head_q];
      end
      if (mispredict) begin
        // Flush wins over any same-edge issue or CDB write: those belong to the wrong path.
        clear_pc_q <= target_q[head_q];
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        done_q     <= '0;
      end else begin
        if (do_issue) begin
          kind_q[tail_q] <= issue_kind_i;
          rd_q[tail_q]   <= issue_rd_i;
          pred_q[tail_q] <= issue_pred_i;
          done_q[tail_q] <= 1'b0;
          tail_q         <= tail_q + ROB_WIDTH'(1);
        end
        if (do_cdb) begin
          done_q[cdb_pos_i]   <= 1'b1;
          val_q[cdb_pos_i]    <= cdb_val_i;
          taken_q[cdb_pos_i]  <= cdb_taken_i;
          target_q[cdb_pos_i] <= cdb_target_i;
        end
        if (do_commit) head_q <= head_q + ROB_WIDTH'(1);
        count_q <= count_d;
      end
    end
  end

endmodule
